// File: rtl/dev_rx_cmd_pkg.sv
// Shared definitions for the RX command dispatcher: FSM states, command class
// encoding and the credit counter width.
package dev_rx_cmd_pkg;

   localparam int CNT_WIDTH = 4;

   localparam logic CLASS_ADMIN = 1'b0;
   localparam logic CLASS_IO    = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'b001,
      S_CHECK = 3'b010,
      S_ISSUE = 3'b100
   } state_t;

   // The class flag always sits in the top bit of the command word.
   function automatic int class_bit(input int data_width);
      return data_width - 1;
   endfunction

endpackage

// File: rtl/dev_cmd_credit_cnt.sv
// Outstanding-command counter for one class: up on issue, down on retire,
// with a limit compare and a sticky underflow flag.
module dev_cmd_credit_cnt
   import dev_rx_cmd_pkg::*;
#(
   parameter int P_LIMIT = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 inc,
   input  logic                 dec,
   output logic [CNT_WIDTH-1:0] count,
   output logic                 credit_ok,
   output logic                 underflow
);

   logic [CNT_WIDTH-1:0] count_next;
   logic                 underflow_now;

   always_comb begin
      count_next    = count;
      underflow_now = 1'b0;
      if (inc && !dec) begin
         count_next = count + 1'b1;
      end else if (dec && !inc) begin
         if (count == '0) begin
            underflow_now = 1'b1;
         end else begin
            count_next = count - 1'b1;
         end
      end
   end

   // Compare against the post-update value so a retire frees its credit in the same cycle.
   assign credit_ok = (count_next < CNT_WIDTH'(P_LIMIT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count     <= '0;
         underflow <= 1'b0;
      end else begin
         count <= count_next;
         if (underflow_now) begin
            underflow <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/dev_rx_cmd_dispatch.sv
// Pops command words from the RX FIFO, classifies them as admin or I/O, and
// issues each to its engine once the class has an outstanding-command credit.
module dev_rx_cmd_dispatch
   import dev_rx_cmd_pkg::*;
#(
   parameter int P_DATA_WIDTH    = 30,
   parameter int P_ADMIN_CREDITS = 4,
   parameter int P_IO_CREDITS    = 8
) (
   input  logic                    pcie_user_clk,
   input  logic                    pcie_user_rst_n,
   input  logic                    cfg_halt,
   input  logic                    fifo_empty_n,
   input  logic [P_DATA_WIDTH-1:0] fifo_rd_data,
   output logic                    fifo_rd_en,
   output logic                    admin_cmd_valid,
   input  logic                    admin_cmd_ready,
   output logic                    io_cmd_valid,
   input  logic                    io_cmd_ready,
   output logic [P_DATA_WIDTH-2:0] cmd_data,
   input  logic                    admin_cpl,
   input  logic                    io_cpl,
   output logic [CNT_WIDTH-1:0]    admin_outstanding,
   output logic [CNT_WIDTH-1:0]    io_outstanding,
   output logic                    cpl_underflow
);

   localparam int CLASS_BIT = class_bit(P_DATA_WIDTH);

   state_t                  state;
   state_t                  next_state;
   logic [P_DATA_WIDTH-1:0] holding;
   logic                    held_class;
   logic                    admin_ok;
   logic                    io_ok;
   logic                    admin_uf;
   logic                    io_uf;

   assign held_class = holding[CLASS_BIT];
   assign cmd_data   = holding[P_DATA_WIDTH-2:0];

   always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
      if (!pcie_user_rst_n) begin
         state   <= S_IDLE;
         holding <= '0;
      end else begin
         state <= next_state;
         if (fifo_rd_en) begin
            holding <= fifo_rd_data;
         end
      end
   end

   // The pop strobe is gated by reset so no FIFO word is lost while held in reset.
   always_comb begin
      next_state      = state;
      fifo_rd_en      = 1'b0;
      admin_cmd_valid = 1'b0;
      io_cmd_valid    = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (pcie_user_rst_n && fifo_empty_n && !cfg_halt) begin
               fifo_rd_en = 1'b1;
               next_state = S_CHECK;
            end
         end
         S_CHECK: begin
            if ((held_class == CLASS_IO) ? io_ok : admin_ok) begin
               next_state = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (held_class == CLASS_ADMIN) begin
               admin_cmd_valid = 1'b1;
               if (admin_cmd_ready) begin
                  next_state = S_IDLE;
               end
            end else begin
               io_cmd_valid = 1'b1;
               if (io_cmd_ready) begin
                  next_state = S_IDLE;
               end
            end
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase
   end

   dev_cmd_credit_cnt #(
      .P_LIMIT (P_ADMIN_CREDITS)
   ) u_admin_cnt (
      .clk       (pcie_user_clk),
      .rst_n     (pcie_user_rst_n),
      .inc       (admin_cmd_valid & admin_cmd_ready),
      .dec       (admin_cpl),
      .count     (admin_outstanding),
      .credit_ok (admin_ok),
      .underflow (admin_uf)
   );

   dev_cmd_credit_cnt #(
      .P_LIMIT (P_IO_CREDITS)
   ) u_io_cnt (
      .clk       (pcie_user_clk),
      .rst_n     (pcie_user_rst_n),
      .inc       (io_cmd_valid & io_cmd_ready),
      .dec       (io_cpl),
      .count     (io_outstanding),
      .credit_ok (io_ok),
      .underflow (io_uf)
   );

   assign cpl_underflow = admin_uf | io_uf;

endmodule

// File: tb/tb_dev_rx_cmd_dispatch.sv
// Bench for dev_rx_cmd_dispatch: directed scenarios plus a random phase, all
// checked every cycle against a transaction-level model of the dispatcher.
module tb_dev_rx_cmd_dispatch;

   localparam int W  = 30;
   localparam int AL = 4;
   localparam int IL = 8;

   logic          pcie_user_clk = 1'b0;
   logic          pcie_user_rst_n = 1'b0;
   logic          cfg_halt = 1'b0;
   logic          fifo_empty_n = 1'b0;
   logic [W-1:0]  fifo_rd_data = '0;
   logic          fifo_rd_en;
   logic          admin_cmd_valid;
   logic          admin_cmd_ready = 1'b0;
   logic          io_cmd_valid;
   logic          io_cmd_ready = 1'b0;
   logic [W-2:0]  cmd_data;
   logic          admin_cpl = 1'b0;
   logic          io_cpl = 1'b0;
   logic [3:0]    admin_outstanding;
   logic [3:0]    io_outstanding;
   logic          cpl_underflow;

   always #5 pcie_user_clk = ~pcie_user_clk;

   dev_rx_cmd_dispatch #(
      .P_DATA_WIDTH    (W),
      .P_ADMIN_CREDITS (AL),
      .P_IO_CREDITS    (IL)
   ) dut (
      .pcie_user_clk     (pcie_user_clk),
      .pcie_user_rst_n   (pcie_user_rst_n),
      .cfg_halt          (cfg_halt),
      .fifo_empty_n      (fifo_empty_n),
      .fifo_rd_data      (fifo_rd_data),
      .fifo_rd_en        (fifo_rd_en),
      .admin_cmd_valid   (admin_cmd_valid),
      .admin_cmd_ready   (admin_cmd_ready),
      .io_cmd_valid      (io_cmd_valid),
      .io_cmd_ready      (io_cmd_ready),
      .cmd_data          (cmd_data),
      .admin_cpl         (admin_cpl),
      .io_cpl            (io_cpl),
      .admin_outstanding (admin_outstanding),
      .io_outstanding    (io_outstanding),
      .cpl_underflow     (cpl_underflow)
   );

   int checks = 0;
   int failures = 0;

   // drv_q is the physical FIFO seen by the DUT; mdl_q is the model's view of it.
   logic [W-1:0] drv_q[$];
   logic [W-1:0] mdl_q[$];

   // Model: 0 = nothing held, 1 = holding a word awaiting credit, 2 = presenting it.
   int           m_phase = 0;
   logic [W-1:0] m_held = '0;
   int           m_cnt[2] = '{0, 0};
   bit           m_uf = 1'b0;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_fifo();
      fifo_empty_n = (drv_q.size() != 0);
      fifo_rd_data = (drv_q.size() != 0) ? drv_q[0] : '0;
   endtask

   task automatic push_word(input logic [W-1:0] word);
      drv_q.push_back(word);
      mdl_q.push_back(word);
      drive_fifo();
   endtask

   // One clock: drive inputs, check every output at the negedge, advance the model.
   task automatic apply_stimulus(input logic h, input logic ar, input logic ir,
                                 input logic ac, input logic ic);
      int   n_cnt[2];
      bit   hs[2];
      bit   cpl[2];
      logic cls;
      logic exp_rd;
      logic dut_pop;
      int   lim;
      cfg_halt = h;
      admin_cmd_ready = ar;
      io_cmd_ready = ir;
      admin_cpl = ac;
      io_cpl = ic;
      drive_fifo();
      @(negedge pcie_user_clk);
      cls = m_held[W-1];
      exp_rd = (m_phase == 0) && (mdl_q.size() != 0) && !h;
      check_output("fifo_rd_en", 32'(fifo_rd_en), 32'(exp_rd));
      check_output("admin_cmd_valid", 32'(admin_cmd_valid), 32'(m_phase == 2 && cls == 1'b0));
      check_output("io_cmd_valid", 32'(io_cmd_valid), 32'(m_phase == 2 && cls == 1'b1));
      if (m_phase == 2) check_output("cmd_data", 32'(cmd_data), 32'(m_held[W-2:0]));
      check_output("admin_outstanding", 32'(admin_outstanding), 32'(m_cnt[0]));
      check_output("io_outstanding", 32'(io_outstanding), 32'(m_cnt[1]));
      check_output("cpl_underflow", 32'(cpl_underflow), 32'(m_uf));
      dut_pop = fifo_rd_en;
      hs[0] = (m_phase == 2) && (cls == 1'b0) && ar;
      hs[1] = (m_phase == 2) && (cls == 1'b1) && ir;
      cpl[0] = ac;
      cpl[1] = ic;
      for (int c = 0; c < 2; c++) begin
         n_cnt[c] = m_cnt[c];
         if (hs[c] && !cpl[c]) n_cnt[c] = m_cnt[c] + 1;
         else if (cpl[c] && !hs[c]) begin
            if (m_cnt[c] == 0) m_uf = 1'b1;
            else n_cnt[c] = m_cnt[c] - 1;
         end
      end
      case (m_phase)
         0: if (exp_rd) begin
               m_held = mdl_q.pop_front();
               m_phase = 1;
            end
         1: begin
               lim = cls ? IL : AL;
               if (n_cnt[cls] < lim) m_phase = 2;
            end
         default: if (hs[cls]) m_phase = 0;
      endcase
      m_cnt = n_cnt;
      @(posedge pcie_user_clk);
      #1;
      if (dut_pop && drv_q.size() != 0) void'(drv_q.pop_front());
      drive_fifo();
   endtask

   task automatic run_until(input int tgt, input logic h, input logic ar, input logic ir,
                            input logic ac, input logic ic, input int maxc);
      int n = 0;
      while (m_phase != tgt && n < maxc) begin
         apply_stimulus(h, ar, ir, ac, ic);
         n++;
      end
      if (m_phase != tgt) begin
         failures++;
         $display("[TB] FAIL wait_phase observed=%0d required=%0d", m_phase, tgt);
      end
   endtask

   // Asserts reset from wherever the bench currently is and checks outputs clear at once.
   task automatic do_reset();
      pcie_user_rst_n = 1'b0;
      #1;
      check_output("rst_admin_valid", 32'(admin_cmd_valid), 32'd0);
      check_output("rst_io_valid", 32'(io_cmd_valid), 32'd0);
      check_output("rst_fifo_rd_en", 32'(fifo_rd_en), 32'd0);
      check_output("rst_cmd_data", 32'(cmd_data), 32'd0);
      check_output("rst_admin_cnt", 32'(admin_outstanding), 32'd0);
      check_output("rst_io_cnt", 32'(io_outstanding), 32'd0);
      check_output("rst_underflow", 32'(cpl_underflow), 32'd0);
      repeat (2) @(posedge pcie_user_clk);
      #1;
      check_output("rst_hold_rd_en", 32'(fifo_rd_en), 32'd0);
      m_phase = 0;
      m_held = '0;
      m_cnt = '{0, 0};
      m_uf = 1'b0;
      pcie_user_rst_n = 1'b1;
   endtask

   initial begin
      logic [W-1:0] w;
      do_reset();
      repeat (3) apply_stimulus(0, 1, 1, 0, 0);

      // Single admin command with known data.
      push_word(30'h0ABCDEF1);
      repeat (5) apply_stimulus(0, 1, 1, 0, 0);
      check_output("single_admin_cnt", 32'(admin_outstanding), 32'd1);

      // Nine I/O commands with no retirement: the ninth parks for credit.
      for (int i = 0; i < 9; i++) begin
         w = {1'b1, 29'($urandom)};
         push_word(w);
      end
      repeat (40) apply_stimulus(0, 1, 1, 0, 0);
      check_output("io_exhaust_cnt", 32'(io_outstanding), 32'd8);
      check_output("io_exhaust_fifo_empty", 32'(fifo_empty_n), 32'd0);
      apply_stimulus(0, 1, 1, 0, 1);
      repeat (4) apply_stimulus(0, 1, 1, 0, 0);
      check_output("io_ninth_cnt", 32'(io_outstanding), 32'd8);

      // Retire all I/O, then hold off the I/O engine for five cycles.
      repeat (8) apply_stimulus(0, 1, 1, 0, 1);
      push_word({1'b1, 29'h15A5A5A5});
      run_until(2, 0, 1, 0, 0, 0, 10);
      repeat (5) apply_stimulus(0, 1, 0, 0, 0);
      apply_stimulus(0, 1, 1, 0, 0);
      apply_stimulus(0, 1, 1, 0, 0);
      check_output("backpressure_cnt", 32'(io_outstanding), 32'd1);

      // Admin handshake coinciding with an admin retirement at count 2.
      push_word({1'b0, 29'h01234567});
      push_word({1'b0, 29'h1FEDCBA9});
      run_until(2, 0, 1, 1, 0, 0, 10);
      apply_stimulus(0, 1, 1, 0, 0);
      run_until(2, 0, 1, 1, 0, 0, 10);
      apply_stimulus(0, 1, 1, 1, 0);
      apply_stimulus(0, 1, 1, 0, 0);
      check_output("simul_admin_cnt", 32'(admin_outstanding), 32'd2);

      // I/O retirement at zero count sets the sticky underflow flag.
      apply_stimulus(0, 1, 1, 0, 1);
      apply_stimulus(0, 1, 1, 0, 1);
      check_output("underflow_cnt", 32'(io_outstanding), 32'd0);
      check_output("underflow_flag", 32'(cpl_underflow), 32'd1);
      repeat (3) apply_stimulus(0, 1, 1, 0, 0);
      check_output("underflow_sticky", 32'(cpl_underflow), 32'd1);

      // Random traffic, halts, backpressure and retirements.
      for (int i = 0; i < 400; i++) begin
         if (drv_q.size() < 6 && $urandom_range(0, 2) == 0) begin
            w = W'($urandom);
            push_word(w);
         end
         apply_stimulus($urandom_range(0, 4) == 0, 1'($urandom), 1'($urandom),
                        $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      end

      // Drain to idle, then halt with words waiting.
      run_until(0, 0, 1, 1, 1, 1, 50);
      push_word({1'b0, 29'h0000BEEF});
      push_word({1'b1, 29'h0000CAFE});
      repeat (10) apply_stimulus(1, 1, 1, 0, 0);
      check_output("halt_fifo_kept", 32'(fifo_empty_n), 32'd1);

      // Release halt, catch the next command in issue with ready low, then reset.
      run_until(2, 0, 0, 0, 1, 1, 20);
      cfg_halt = 1'b0;
      admin_cmd_ready = 1'b0;
      io_cmd_ready = 1'b0;
      admin_cpl = 1'b0;
      io_cpl = 1'b0;
      do_reset();
      repeat (12) apply_stimulus(0, 1, 1, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dev_rx_cmd_dispatch.md
Name: dev_rx_cmd_dispatch

Overview:
Read-side controller for the device RX command FIFO. Pops command words, classifies each as admin or I/O, and enforces a per-class outstanding-command credit limit. Presents each command on a valid/ready port to the matching downstream engine. Sits between the RX command FIFO read port and the admin/I/O command engines.

Parameters:
P_DATA_WIDTH, 30, command word width; bit [P_DATA_WIDTH-1] is the class (0 = admin, 1 = I/O).
P_ADMIN_CREDITS, 4, maximum outstanding admin commands (1..15).
P_IO_CREDITS, 8, maximum outstanding I/O commands (1..15).

Ports:
pcie_user_clk  in  1  block clock.
pcie_user_rst_n  in  1  reset, asynchronous assert, active-low.
cfg_halt  in  1  when 1, no new pop starts; a command already held completes normally.
fifo_empty_n  in  1  FIFO has data. Read is first-word-fall-through: fifo_rd_data is valid while this is 1.
fifo_rd_data  in  P_DATA_WIDTH  head FIFO word.
fifo_rd_en  out  1  single-cycle pop strobe.
admin_cmd_valid  out  1  admin command presented.
admin_cmd_ready  in  1  admin engine accepts.
io_cmd_valid  out  1  I/O command presented.
io_cmd_ready  in  1  I/O engine accepts.
cmd_data  out  P_DATA_WIDTH-1  held command, class bit stripped; shared by both ports.
admin_cpl  in  1  one admin command retired (pulse).
io_cpl  in  1  one I/O command retired (pulse).
admin_outstanding  out  4  current admin count.
io_outstanding  out  4  current I/O count.
cpl_underflow  out  1  sticky error flag.

Behaviour:
- Reset: clock and reset as stated in Ports. All of the following are 0 at reset: outputs, counters, holding register, cpl_underflow. FSM resets to S_IDLE. Reset mid-operation drops any held command silently; the FIFO entry is not restored.
- FSM states are S_IDLE, S_CHECK and S_ISSUE; they are one-hot.
- S_IDLE: when fifo_empty_n=1 and cfg_halt=0:
  - fifo_rd_en=1 for exactly that cycle;
  - fifo_rd_data is captured into the holding register;
  - next state is S_CHECK.
  Otherwise fifo_rd_en=0.
- S_CHECK: if the held class count is below its credit limit, go to S_ISSUE; otherwise stay. Stalling for credit never pops the FIFO again and never asserts either valid.
- S_ISSUE:
  - Assert the valid for the held class only; the other valid stays 0.
  - cmd_data = holding[P_DATA_WIDTH-2:0], stable while valid is asserted.
  - Valid stays high until ready is 1 on the same cycle.
  - On that handshake, the class count increments and the FSM returns to S_IDLE. The next pop can occur on the following cycle.
- Latency: pop cycle N → valid on cycle N+2 when a credit is available.
- Throughput: at most one command per 3 cycles. This is deliberate, because the FIFO's pointer sync is slower than that.
- Counter update per cycle, per class: next = count + issue_handshake − cpl.
  - Simultaneous handshake and completion: count unchanged.
  - Completion while count = 0: count stays 0 and cpl_underflow sets. Only reset clears it.
  - Count never exceeds its credit limit; an increment is impossible at the limit by construction.
- A completion in S_CHECK that frees a credit lets the FSM move to S_ISSUE on the next cycle. S_CHECK samples the count after that cycle's completion has been applied.
- cfg_halt raised in S_CHECK or S_ISSUE does not abort the held command.
- cmd_data is don't-care while both valids are 0, but it is driven from the holding register and therefore never X after reset.

Decomposition:
- Shared package dev_rx_cmd_pkg holds:
  - state encodings S_IDLE/S_CHECK/S_ISSUE;
  - the class-bit position and the CLASS_ADMIN/CLASS_IO constants;
  - the credit counter width (4).
- One sub-module is natural: dev_cmd_credit_cnt, an up/down counter with a limit compare and underflow flag, instantiated twice (admin, I/O).

Test Plan:
- Single admin command: word 0x0ABCDEF1 (bit29=0) in FIFO → fifo_rd_en pulse on cycle N, admin_cmd_valid on N+2, cmd_data=0x0ABCDEF1, admin_outstanding 0→1 on the handshake; io_cmd_valid stays 0.
- I/O credit exhaustion: 9 I/O words, no io_cpl → exactly 8 issued, io_outstanding=8, FSM parks in S_CHECK with one FIFO pop consumed and fifo_rd_en held 0; then one io_cpl → 9th issued, count stays 8.
- Backpressure: io_cmd_ready=0 for 5 cycles → io_cmd_valid and cmd_data stable across all 5 cycles; no further pops; handshake on the 6th cycle.
- Simultaneous events: handshake and admin_cpl on the same cycle with count=2 → count remains 2.
- Underflow: io_cpl with io_outstanding=0 → count stays 0, cpl_underflow=1 and remains 1 until reset.
- Halt and reset: cfg_halt=1 with FIFO non-empty → fifo_rd_en never asserts. Reset asserted in S_ISSUE → valids drop to 0 immediately, counters clear, FSM returns to S_IDLE after release.
